// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the inverse cipher:
//   - SBOX / INV_SBOX byte tables (byte 0 of each table sits in the MSBs)
//   - rcon lookup, GF(2^8) helpers (polynomial 0x11b)
//   - word/state transforms: sub_word, rot_word, inv_shift_rows,
//     inv_sub_bytes, inv_mix_columns
//   - state_e: controller states of aes_decrypt
// State layout: byte i = bits [127-8i -: 8], column-major (byte = row + 4*col).
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYEXP = 3'd1,
    INIT   = 3'd2,
    ROUND  = 3'd3,
    FINAL  = 3'd4
  } state_e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // MSB position of table entry b is 2047 - 8*b = {~b, 3'b111}
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b111} -: 8];
  endfunction

  // rcon[1..10]; index 0 and 11..15 never occur in a legal schedule
  function automatic logic [7:0] rcon_lookup(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Row r rotates right by r columns
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// ---------------------------------------------------------------------------
// aes_key_step
// One AES-128 key-schedule step, combinational, usable in both directions.
//   key      in  128  current round key (word 0 = bits [127:96])
//   rcon     in  8    round constant for this step
//   dir      in  1    0 = forward rk(r-1)->rk(r), 1 = inverse rk(r)->rk(r-1)
//   next_key out 128  resulting round key
// ---------------------------------------------------------------------------
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  input  logic         dir,
  output logic [127:0] next_key
);

  logic [31:0] w0_s, w1_s, w2_s, w3_s;
  logic [31:0] n0_s, n1_s, n2_s, n3_s;

  assign w0_s = key[127:96];
  assign w1_s = key[95:64];
  assign w2_s = key[63:32];
  assign w3_s = key[31:0];

  // Forward chain starts from word 0; inverse chain must first undo words 3..1
  // because the new word 0 depends on the recovered word 3.
  always_comb begin
    if (dir) begin
      n3_s = w3_s ^ w2_s;
      n2_s = w2_s ^ w1_s;
      n1_s = w1_s ^ w0_s;
      n0_s = w0_s ^ sub_word(rot_word(n3_s)) ^ {rcon, 24'h000000};
    end else begin
      n0_s = w0_s ^ sub_word(rot_word(w3_s)) ^ {rcon, 24'h000000};
      n1_s = w1_s ^ n0_s;
      n2_s = w2_s ^ n1_s;
      n3_s = w3_s ^ n2_s;
    end
  end

  assign next_key = {n0_s, n1_s, n2_s, n3_s};

endmodule

// File: rtl/aes_decrypt.sv
// ---------------------------------------------------------------------------
// aes_decrypt
// Iterative AES-128 inverse cipher, one round per clock. The cipher key is
// expanded forward to rk10, then the schedule is rolled back one step per
// round alongside the state.
//   clk          in  1    rising-edge clock
//   rst          in  1    synchronous active-high reset
//   start        in  1    request, sampled only while ready=1
//   block_in     in  128  ciphertext, captured on start&&ready
//   key_in       in  128  cipher key, captured on start&&ready
//   ready        out 1    high in IDLE
//   result       out 128  plaintext, held until next completion
//   result_valid out 1    one-cycle pulse when result updates
// Optional feature macro: AES_DECRYPT_KEY_CACHE_EN (cache of the last
// expanded key; a hit skips KEYEXP, 11-cycle latency instead of 21).
// ---------------------------------------------------------------------------
module aes_decrypt #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] block_in,
  input  logic [127:0] key_in,
  output logic         ready,
  output logic [127:0] result,
  output logic         result_valid
);
  import aes_pkg::*;

  if (ROUNDS != 32'sd10) begin : g_rounds_check
    $error("aes_decrypt: only ROUNDS=10 (AES-128) is supported");
  end

  localparam logic [3:0] NR = 4'(ROUNDS);

  state_e       state_q, state_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [3:0]   rcon_idx_q, rcon_idx_d;
  logic [127:0] result_q, result_d;
  logic         result_valid_q, result_valid_d;

  logic [127:0] ks_next_s;
  logic [7:0]   ks_rcon_s;
  logic         ks_dir_s;
  logic [127:0] inv_sr_s;

`ifdef AES_DECRYPT_KEY_CACHE_EN
  logic [127:0] key0_q, key0_d;
  logic [127:0] cache_key_q, cache_key_d;
  logic [127:0] cache_rk10_q, cache_rk10_d;
  logic         cache_valid_q, cache_valid_d;
`endif

  aes_key_step u_key_step (
    .key      (key_q),
    .rcon     (ks_rcon_s),
    .dir      (ks_dir_s),
    .next_key (ks_next_s)
  );

  assign inv_sr_s = inv_sub_bytes(inv_shift_rows(blk_q));

  // Controller next-state, datapath and key-schedule sequencing
  always_comb begin
    state_d        = state_q;
    blk_d          = blk_q;
    key_d          = key_q;
    rnd_d          = rnd_q;
    rcon_idx_d     = rcon_idx_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    ks_dir_s       = 1'b0;
    ks_rcon_s      = rcon_lookup(rcon_idx_q);
`ifdef AES_DECRYPT_KEY_CACHE_EN
    key0_d         = key0_q;
    cache_key_d    = cache_key_q;
    cache_rk10_d   = cache_rk10_q;
    cache_valid_d  = cache_valid_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          blk_d      = block_in;
          rcon_idx_d = 4'd1;
`ifdef AES_DECRYPT_KEY_CACHE_EN
          key0_d = key_in;
          if (cache_valid_q && (key_in == cache_key_q)) begin
            key_d   = cache_rk10_q;
            state_d = INIT;
          end else begin
            key_d   = key_in;
            state_d = KEYEXP;
          end
`else
          key_d   = key_in;
          state_d = KEYEXP;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      KEYEXP: begin
        ks_dir_s = 1'b0;
        key_d    = ks_next_s;
        if (rcon_idx_q == NR) begin
          state_d = INIT;
`ifdef AES_DECRYPT_KEY_CACHE_EN
          cache_key_d   = key0_q;
          cache_rk10_d  = ks_next_s;
          cache_valid_d = 1'b1;
`endif
        end else begin
          rcon_idx_d = rcon_idx_q + 4'd1;
        end
      end
      INIT: begin
        blk_d   = blk_q ^ key_q;
        rnd_d   = NR - 4'd1;
        state_d = ROUND;
      end
      ROUND: begin
        // key_q holds rk(rnd+1); stepping back to rk(rnd) uses rcon[rnd+1]
        ks_dir_s  = 1'b1;
        ks_rcon_s = rcon_lookup(rnd_q + 4'd1);
        key_d     = ks_next_s;
        blk_d     = inv_mix_columns(inv_sr_s ^ ks_next_s);
        rnd_d     = rnd_q - 4'd1;
        if (rnd_q == 4'd1) begin
          state_d = FINAL;
        end else begin
          state_d = ROUND;
        end
      end
      FINAL: begin
        ks_dir_s       = 1'b1;
        ks_rcon_s      = rcon_lookup(4'd1);
        key_d          = ks_next_s;
        result_d       = inv_sr_s ^ ks_next_s;
        result_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Main state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      blk_q          <= 128'h0;
      key_q          <= 128'h0;
      rnd_q          <= 4'd0;
      rcon_idx_q     <= 4'd0;
      result_q       <= 128'h0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      blk_q          <= blk_d;
      key_q          <= key_d;
      rnd_q          <= rnd_d;
      rcon_idx_q     <= rcon_idx_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

`ifdef AES_DECRYPT_KEY_CACHE_EN
  // Expanded-key cache registers
  always_ff @(posedge clk) begin
    if (rst) begin
      key0_q        <= 128'h0;
      cache_key_q   <= 128'h0;
      cache_rk10_q  <= 128'h0;
      cache_valid_q <= 1'b0;
    end else begin
      key0_q        <= key0_d;
      cache_key_q   <= cache_key_d;
      cache_rk10_q  <= cache_rk10_d;
      cache_valid_q <= cache_valid_d;
    end
  end
`endif

  assign ready        = (state_q == IDLE);
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_aes_decrypt.sv
// ---------------------------------------------------------------------------
// tb_aes_decrypt
// Self-checking bench for aes_decrypt. Reference: a forward AES-128 cipher
// built from GF(2^8) arithmetic; random plaintexts are encrypted here and the
// DUT must return the plaintext. Known-answer vectors come from FIPS-197.
// ---------------------------------------------------------------------------
module tb_aes_decrypt;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] block_in;
  logic [127:0] key_in;
  logic         ready;
  logic [127:0] result;
  logic         result_valid;

  int checks   = 0;
  int failures = 0;

`ifdef AES_DECRYPT_KEY_CACHE_EN
  localparam int HIT_LAT = 11;
`else
  localparam int HIT_LAT = 21;
`endif

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_decrypt #(.ROUNDS(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .block_in     (block_in),
    .key_in       (key_in),
    .ready        (ready),
    .result       (result),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box = affine transform of the multiplicative inverse
  task automatic build_sbox;
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
    end
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h000000};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++) s[row+4*c] = t[row+4*((c+row)%4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  // Call while ready=1, away from the clock edge; returns 1 ns after acceptance edge.
  task automatic issue(input logic [127:0] b, input logic [127:0] k);
    start    = 1'b1;
    block_in = b;
    key_in   = k;
    @(posedge clk);
    #1;
    start    = 1'b0;
    block_in = rnd128();
    key_in   = rnd128();
  endtask

  // Cycles from acceptance until result_valid is seen (0 = timeout).
  // With busy=1, random ignored start pulses are driven while waiting.
  task automatic wait_done(input bit busy, output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (result_valid === 1'b1) begin
        lat = k;
        break;
      end
      if (busy) begin
        start    = 1'($urandom_range(0, 1));
        block_in = rnd128();
        key_in   = rnd128();
      end
    end
    start = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1; start = 1'b0; block_in = 128'h0; key_in = 128'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
    checks++; if (result !== 128'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
  endtask

  task automatic test_fips_c1;
    int lat;
    @(negedge clk);
    issue(C1_CT, C1_KEY);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL c1_busy_ready got=%b exp=0", ready); end
    wait_done(1'b0, lat);
    checks++; if (lat != 21) begin failures++; $display("FAIL c1_latency got=%0d exp=21", lat); end
    checks++; if (result !== C1_PT) begin failures++; $display("FAIL c1_result got=%h exp=%h", result, C1_PT); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL c1_ready_at_valid got=%b exp=1", ready); end
    @(negedge clk);
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL c1_pulse_width got=%b exp=0", result_valid); end
  endtask

  task automatic test_cache;
    int lat;
    @(negedge clk);
    issue(C1_CT, C1_KEY);
    wait_done(1'b0, lat);
    checks++; if (lat != HIT_LAT) begin failures++; $display("FAIL cache_repeat_latency got=%0d exp=%0d", lat, HIT_LAT); end
    checks++; if (result !== C1_PT) begin failures++; $display("FAIL cache_repeat_result got=%h exp=%h", result, C1_PT); end
  endtask

  task automatic test_fips_b;
    int lat;
    @(negedge clk);
    issue(B_CT, B_KEY);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 10) begin
        checks++;
        if (dut.key_q !== B_RK10) begin failures++; $display("FAIL b_rk10_at_init got=%h exp=%h", dut.key_q, B_RK10); end
      end
      if (result_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++; if (lat != 21) begin failures++; $display("FAIL b_latency got=%0d exp=21", lat); end
    checks++; if (result !== B_PT) begin failures++; $display("FAIL b_result got=%h exp=%h", result, B_PT); end
  endtask

  task automatic test_random;
    logic [127:0] pt, k;
    int lat;
    for (int n = 0; n < 6; n++) begin
      pt = rnd128();
      k  = rnd128();
      @(negedge clk);
      issue(ref_encrypt(pt, k), k);
      wait_done(1'b0, lat);
      checks++; if (lat != 21) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=21", n, lat); end
      checks++; if (result !== pt) begin failures++; $display("FAIL rand%0d_result got=%h exp=%h", n, result, pt); end
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] pt1, k1, pt2, k2;
    int lat, pulses, busy_cycles;
    pt1 = rnd128(); k1 = rnd128();
    pt2 = rnd128(); k2 = rnd128();
    @(negedge clk);
    issue(ref_encrypt(pt1, k1), k1);
    wait_done(1'b1, lat);
    checks++; if (lat != 21) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=21", lat); end
    checks++; if (result !== pt1) begin failures++; $display("FAIL b2b_first_result got=%h exp=%h", result, pt1); end
    // still in the result_valid cycle: issue the next block with no bubble
    issue(ref_encrypt(pt2, k2), k2);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL b2b_accept_no_bubble ready=%b exp=0", ready); end
    wait_done(1'b1, lat);
    checks++; if (lat != 21) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=21", lat); end
    checks++; if (result !== pt2) begin failures++; $display("FAIL b2b_second_result got=%h exp=%h", result, pt2); end
    pulses = 0; busy_cycles = 0;
    repeat (25) begin
      @(negedge clk);
      if (result_valid === 1'b1) pulses++;
      if (ready !== 1'b1) busy_cycles++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL b2b_extra_valid got=%0d exp=0", pulses); end
    checks++; if (busy_cycles != 0) begin failures++; $display("FAIL b2b_queued_start busy_cycles=%0d exp=0", busy_cycles); end
  endtask

  task automatic test_reset_mid_op;
    logic [127:0] pt, k;
    int lat, pulses;
    pt = rnd128(); k = rnd128();
    @(negedge clk);
    issue(ref_encrypt(pt, k), k);
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", ready); end
    checks++; if (result !== 128'h0) begin failures++; $display("FAIL midrst_result got=%h exp=0", result); end
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (result_valid === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL midrst_valid_pulses got=%0d exp=0", pulses); end
    pt = rnd128(); k = rnd128();
    issue(ref_encrypt(pt, k), k);
    wait_done(1'b0, lat);
    checks++; if (lat != 21) begin failures++; $display("FAIL midrst_new_latency got=%0d exp=21", lat); end
    checks++; if (result !== pt) begin failures++; $display("FAIL midrst_new_result got=%h exp=%h", result, pt); end
  endtask

  task automatic test_hold;
    int lat, bad_res, bad_vld;
    @(negedge clk);
    issue(C1_CT, C1_KEY);
    wait_done(1'b0, lat);
    checks++; if (result !== C1_PT) begin failures++; $display("FAIL hold_initial got=%h exp=%h", result, C1_PT); end
    bad_res = 0; bad_vld = 0;
    repeat (50) begin
      @(negedge clk);
      if (result !== C1_PT) bad_res++;
      if (result_valid !== 1'b0) bad_vld++;
    end
    checks++; if (bad_res != 0) begin failures++; $display("FAIL hold_result bad_cycles=%0d exp=0 last=%h", bad_res, result); end
    checks++; if (bad_vld != 0) begin failures++; $display("FAIL hold_valid bad_cycles=%0d exp=0", bad_vld); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    test_reset();
    test_fips_c1();
    test_cache();
    test_fips_b();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
